// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - request/response bundle between the EX stage and the mul/div unit
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  // EX stage side: issues requests, watches busy/done
  modport master (
    output start, flush, op, a, b, rd_in,
    input  busy, done, result, rd_out
  );

  // mul/div unit side
  modport slave (
    input  start, flush, op, a, b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the execute stage
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            sign_a;
  logic            sign_b;
  // rem doubles as the product high half during multiplies
  logic [XLEN-1:0] rem;
  // quo holds the multiplier / dividend bits and collects product low half / quotient bits
  logic [XLEN-1:0] quo;
  // dvs is the multiplicand for multiplies and the divisor for divides
  logic [XLEN-1:0] dvs;
  logic [CW-1:0]   cnt;

  logic            in_sign_a;
  logic            in_sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] sub_lo;
  logic [XLEN:0]   sum;

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fix_res;

  // operand signs and magnitudes as seen on the accept cycle
  always_comb begin
    in_sign_a = 1'b0;
    in_sign_b = 1'b0;
    case (bus.op)
      3'd1, 3'd4, 3'd6: begin
        in_sign_a = bus.a[XLEN-1];
        in_sign_b = bus.b[XLEN-1];
      end
      3'd2: in_sign_a = bus.a[XLEN-1];
      default: ;
    endcase
    mag_a = in_sign_a ? (~bus.a + 1'b1) : bus.a;
    mag_b = in_sign_b ? (~bus.b + 1'b1) : bus.b;
  end

  // divide-by-zero and signed overflow bypass the iteration entirely
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (bus.op[2]) begin
      if (bus.b == '0) begin
        fast     = 1'b1;
        fast_res = bus.op[1] ? bus.a : '1;
      end else if (!bus.op[0] && bus.a == MIN_NEG && bus.b == '1) begin
        fast     = 1'b1;
        fast_res = bus.op[1] ? '0 : bus.a;
      end
    end
  end

  // one radix-2 step: restoring divide trial and shift-add multiply
  always_comb begin
    trial  = {rem, quo[XLEN-1]};
    ge     = (trial >= {1'b0, dvs});
    sub_lo = trial[XLEN-1:0] - dvs;
    sum    = {1'b0, rem} + (quo[0] ? {1'b0, dvs} : '0);
  end

  // sign correction and half/quotient/remainder selection for FIXUP
  always_comb begin
    prod     = {rem, quo};
    prod_fix = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
    case (op_q)
      3'd0:             fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_res = (sign_a ^ sign_b) ? (~quo + 1'b1) : quo;
      default:          fix_res = sign_a ? (~rem + 1'b1) : rem;
    endcase
  end

  // control FSM and datapath registers; flush overrides everything but reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.rd_out <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      cnt        <= '0;
    end else if (bus.flush) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
          if (bus.start) begin
            op_q   <= bus.op;
            rd_q   <= bus.rd_in;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            rem    <= '0;
            cnt    <= '0;
            if (bus.op[2]) begin
              dvs <= mag_b;
              quo <= mag_a;
            end else begin
              dvs <= mag_a;
              quo <= mag_b;
            end
            if (fast) begin
              state      <= DONE;
              bus.done   <= 1'b1;
              bus.result <= fast_res;
              bus.rd_out <= bus.rd_in;
            end else begin
              state    <= CALC;
              bus.busy <= 1'b1;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[2]) begin
            rem <= ge ? sub_lo : trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], ge};
          end else begin
            rem <= sum[XLEN:1];
            quo <= {sum[0], quo[XLEN-1:1]};
          end
          if (cnt == LAST) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          state      <= DONE;
          bus.busy   <= 1'b0;
          bus.done   <= 1'b1;
          bus.result <= fix_res;
          bus.rd_out <= rd_q;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for the iterative mul/div unit
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_result = '0;
  logic [4:0]  exp_rd = '0;

  ex_muldiv_if #(.XLEN(32)) bus ();

  ex_muldiv #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference: 64-bit products of extended operands and plain SV division
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    logic        ovf;
    ea  = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
    eb  = (op == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
    p   = ea * eb;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // drive a request for one cycle and queue its expected response
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expv);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.rd_in = rd;
    exp_q.push_back('{res: expv, rd: rd, cyc: cyc + ref_lat(op, a, b)});
    exp_result = expv;
    exp_rd     = rd;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] expv);
    int lat;
    lat = ref_lat(op, a, b);
    issue(op, a, b, rd, expv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("busy", 32'(bus.busy), (k < lat) ? 32'd1 : 32'd0);
      if (k < lat) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    chk("done_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual done=1 required done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", bus.result, e.res);
        chk("rd_out", 32'(bus.rd_out), 32'(e.rd));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual timeout required finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};

  initial begin
    int acc;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rrd;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_rd_out", 32'(bus.rd_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases from the RV32M corner list
    for (int i = 0; i < 12; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], 5'(i + 3), d_exp[i]);
    end

    // flush during cycle 10 of a DIV: no done, outputs keep old values
    acc = cyc;
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd1000; bus.b = 32'd3; bus.rd_in = 5'd21;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < acc + 10) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("busy_before_flush", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("busy_after_flush", 32'(bus.busy), 32'd0);
    chk("result_after_flush", bus.result, exp_result);
    chk("rd_after_flush", 32'(bus.rd_out), 32'(exp_rd));
    repeat (40) begin
      @(posedge clk); #1;
    end

    // start pulses while busy are ignored: exactly one done
    acc = cyc;
    issue(3'd0, 32'd12345, 32'd678, 5'd17, ref_model(3'd0, 32'd12345, 32'd678));
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k >= 5 && k <= 8) begin
        bus.start = 1'b1; bus.op = 3'd5; bus.a = $urandom; bus.b = 32'd0; bus.rd_in = 5'd30;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("busy_start_ignored", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // start together with flush in IDLE: nothing accepted
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.a = 32'd9; bus.b = 32'd0; bus.rd_in = 5'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("start_flush_busy", 32'(bus.busy), 32'd0);
    chk("start_flush_done", 32'(bus.done), 32'd0);
    chk("start_flush_result", bus.result, exp_result);
    repeat (5) begin
      @(posedge clk); #1;
    end

    // reset mid-operation, asserted between edges
    acc = cyc;
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd99; bus.b = 32'd77; bus.rd_in = 5'd11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < acc + 20) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_rd_out", 32'(bus.rd_out), 32'd0);
    exp_result = '0;
    exp_rd     = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'd0, 32'd99, 32'd77, 5'd11, 32'd7623);

    // back-to-back: second start accepted in the DONE cycle
    acc = cyc;
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd5, ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678));
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < acc + 34) begin
      @(posedge clk); #1;
    end
    issue(3'd6, 32'hFFFF_0000, 32'd13, 5'd6, ref_model(3'd6, 32'hFFFF_0000, 32'd13));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
    end
    chk("b2b_done_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      rrd = 5'($urandom_range(0, 31));
      run_op(rop, ra, rb, rrd, ref_model(rop, ra, rb));
    end

    repeat (5) begin
      @(posedge clk); #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
